// File: rtl/fir_seq_mac_hs_if.sv
// Ready/valid bus for the sequential-MAC FIR: sample in, result out, and
// coefficient programming port.
//   master: drives x_in/in_valid, out_ready, coef_we/coef_addr/coef_data
//   slave : drives in_ready, y_out/out_valid, coef_ready
interface fir_seq_mac_hs_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned OUT_W  = 32
);
    localparam int unsigned AW = $clog2(TAPS);

    logic signed [DATA_W-1:0] x_in;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  y_out;
    logic                     out_valid;
    logic                     out_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_ready;

    modport master (
        output x_in, in_valid, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, y_out, out_valid, coef_ready
    );

    modport slave (
        input  x_in, in_valid, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, y_out, out_valid, coef_ready
    );
endinterface

// File: rtl/fir_seq_mac_hs.sv
// Time-multiplexed FIR: one signed MAC iterated over TAPS cycles per sample,
// run-time programmable coefficients, ready/valid on input and output.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        fir_seq_mac_hs_if.slave (sample in, result out, coef writes)
// Optional build macro FIR_OUT_SAT_EN: saturate y_out to OUT_W instead of
// two's-complement wrap when the accumulator is wider than the output.
module fir_seq_mac_hs #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned OUT_W  = 32
) (
    input logic             clk,
    input logic             rst,
    fir_seq_mac_hs_if.slave bus
);
    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam int unsigned ACC_W = PW + $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state, state_n;
    logic signed [DATA_W-1:0] x_dl [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            idx;

    logic signed [PW-1:0]     prod_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [OUT_W-1:0]  y_next_c;
    logic                     last_c;
    logic                     accept_c;
    logic                     coef_wr_c;

    // Datapath helpers
    assign prod_c    = PW'(x_dl[idx]) * PW'(coef[idx]);
    assign sum_c     = acc + ACC_W'(prod_c);
    assign last_c    = (idx == AW'(TAPS - 1));
    assign accept_c  = bus.in_valid && bus.in_ready;
    assign coef_wr_c = bus.coef_we && bus.coef_ready && (32'(bus.coef_addr) < TAPS);

    // Reduce the accumulator sum to the output width
    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign y_next_c = OUT_W'(sum_c);
        end else begin : g_red
`ifdef FIR_OUT_SAT_EN
            // Out of range when the bits above the output sign differ from it
            logic ovf_c;
            assign ovf_c    = (sum_c[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){sum_c[ACC_W-1]}});
            assign y_next_c = !ovf_c          ? sum_c[OUT_W-1:0] :
                              sum_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                               {1'b0, {(OUT_W-1){1'b1}}};
`else
            assign y_next_c = sum_c[OUT_W-1:0];
`endif
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept_c)      state_n = MAC;
            MAC:     if (last_c)        state_n = OUT;
            OUT:     if (bus.out_ready) state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    // Delay line, coefficients, accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_dl[k] <= '0;
                coef[k] <= '0;
            end
            acc            <= '0;
            idx            <= '0;
            bus.y_out      <= '0;
            bus.out_valid  <= 1'b0;
            bus.in_ready   <= 1'b1;
            bus.coef_ready <= 1'b1;
        end else begin
            // Both ready flags simply mirror "next state is IDLE"
            bus.in_ready   <= (state_n == IDLE);
            bus.coef_ready <= (state_n == IDLE);
            if (coef_wr_c) coef[bus.coef_addr] <= bus.coef_data;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        x_dl[0] <= bus.x_in;
                        for (int unsigned k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
                        acc <= '0;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= sum_c;
                    idx <= idx + 1'b1;
                    if (last_c) begin
                        bus.y_out     <= y_next_c;
                        bus.out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_seq_mac_hs.sv
// Directed bench for fir_seq_mac_hs: impulse, ramp, backpressure, coefficient
// access rules, mid-MAC reset, accumulator overflow (wrap or FIR_OUT_SAT_EN),
// and out-of-range coefficient address on a TAPS=5 instance.
module tb_fir_seq_mac_hs;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned TAPS   = 4;
    localparam int unsigned OUT_W  = 32;

    logic clk;
    logic rst;

    fir_seq_mac_hs_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();
    fir_seq_mac_hs #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fir_seq_mac_hs_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(5), .OUT_W(OUT_W)) b5 ();
    fir_seq_mac_hs #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(5), .OUT_W(OUT_W)) dut5 (
        .clk(clk), .rst(rst), .bus(b5)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_ov = 1'b0;
    int     acc_q[$];
    int     rise_q[$];
    longint out_q[$];

    int imp_x[5]  = '{1, 0, 0, 0, 0};
    int imp_y[5]  = '{1, 2, 3, 4, 0};
    int ramp_x[5] = '{1, 2, 3, 4, 0};
    int ramp_y[5] = '{1, 3, 6, 10, 9};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.out_valid && bus.out_ready) out_q.push_back(longint'(bus.y_out));
        if (bus.out_valid && !prev_ov) rise_q.push_back(cyc);
        prev_ov <= bus.out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        rise_q.delete();
        out_q.delete();
    endtask

    task automatic write_coef(input int addr, input int data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(addr);
        bus.coef_data = COEF_W'(data);
        tick();
        bus.coef_we   = 1'b0;
    endtask

    // Present a sample, wait until it is accepted, then drop in_valid
    task automatic send(input int x);
        int t = 0;
        bus.x_in     = DATA_W'(x);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", t, 0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (out_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (out_q.size() < n) check("outs_timeout", out_q.size(), n);
        tick();
    endtask

    initial begin
        int t;
        int bad;
        rst = 1'b0;
        bus.x_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        b5.x_in = '0; b5.in_valid = 1'b0; b5.out_ready = 1'b1;
        b5.coef_we = 1'b0; b5.coef_addr = '0; b5.coef_data = '0;
        #2 rst = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_y_out", bus.y_out, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_coef_ready", bus.coef_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Impulse with c = {1,2,3,4}; latency and sample period
        for (int i = 0; i < 4; i++) write_coef(i, i + 1);
        clear_q();
        for (int i = 0; i < 5; i++) send(imp_x[i]);
        wait_outs(5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("impulse_y%0d", i), out_q[i], imp_y[i]);
            check($sformatf("impulse_latency%0d", i), rise_q[i] - (acc_q[i] + 1), TAPS);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("impulse_period%0d", i), acc_q[i+1] - acc_q[i], TAPS + 2);

        // Ramp with c = {1,1,1,1}
        for (int i = 0; i < 4; i++) write_coef(i, 1);
        clear_q();
        for (int i = 0; i < 5; i++) send(ramp_x[i]);
        wait_outs(5);
        for (int i = 0; i < 5; i++) check($sformatf("ramp_y%0d", i), out_q[i], ramp_y[i]);

        // Backpressure: result 12 held, next sample 7 waits
        clear_q();
        bus.out_ready = 1'b0;
        send(5);
        bus.x_in = DATA_W'(7);
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", bus.out_valid, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.y_out !== 32'sd12 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        check("bp_y_held", bus.y_out, 12);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_after_release", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        wait_outs(2);
        check("bp_first_y", out_q[0], 12);
        check("bp_second_y", out_q[1], 16);
        check("bp_accept_count", acc_q.size(), 2);

        // Coefficient write during MAC is dropped; in IDLE it applies at once
        clear_q();
        send(1);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = COEF_W'(5);
        @(negedge clk);
        check("coef_ready_mac", bus.coef_ready, 0);
        tick();
        bus.coef_we = 1'b0;
        send(2);
        wait_outs(2);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = COEF_W'(5);
        send(3);
        bus.coef_we = 1'b0;
        wait_outs(3);
        check("coef_y0", out_q[0], 13);
        check("coef_mac_write_dropped", out_q[1], 15);
        check("coef_idle_write_same_cycle", out_q[2], 25);

        // Reset two cycles into MAC
        send(1);
        tick();
        tick();
        check("mid_in_ready_mac", bus.in_ready, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_y_out", bus.y_out, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_coef_ready", bus.coef_ready, 1);
        tick();
        rst = 1'b0;
        clear_q();
        send(1);
        wait_outs(1);
        check("post_rst_impulse_y", out_q[0], 0);
        check("post_rst_out_count", out_q.size(), 1);

        // Overflow: c = x = -32768
        for (int i = 0; i < 4; i++) write_coef(i, -32768);
        clear_q();
        for (int i = 0; i < 4; i++) send(-32768);
        wait_outs(4);
        check("ovf_y0", out_q[0], 64'sd1073709056);
        check("ovf_y1", out_q[1], 64'sd2147450880);
`ifdef FIR_OUT_SAT_EN
        check("ovf_y2_sat", out_q[2], 64'sd2147483647);
        check("ovf_y3_sat", out_q[3], 64'sd2147483647);
`else
        check("ovf_y2_wrap", out_q[2], -64'sd1073774592);
        check("ovf_y3_wrap", out_q[3], 64'sd0);
`endif

        // TAPS=5 instance: address 5 is ignored, address 0 applies
        b5.coef_we = 1'b1; b5.coef_addr = 3'd5; b5.coef_data = COEF_W'(9);
        tick();
        b5.coef_addr = 3'd0; b5.coef_data = COEF_W'(3);
        tick();
        b5.coef_we = 1'b0;
        b5.x_in = DATA_W'(2); b5.in_valid = 1'b1;
        tick();
        b5.in_valid = 1'b0;
        t = 0;
        while (!b5.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t5_out_valid", b5.out_valid, 1);
        check("t5_y", b5.y_out, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
